// File: rtl/car_pkg.sv
// Shared constants for the counter/address register bank.
package car_pkg;
  localparam int CAR_WIDTH = 16;

  localparam int CAR_PCRA0 = 0;
  localparam int CAR_PCRA1 = 1;
  localparam int CAR_SP    = 2;
  localparam int CAR_SI    = 3;
  localparam int CAR_DI    = 4;

  typedef enum logic [1:0] {
    CAR_STEP_1 = 2'd0,
    CAR_STEP_2 = 2'd1,
    CAR_STEP_4 = 2'd2,
    CAR_STEP_8 = 2'd3
  } car_step_e;
endpackage

// File: rtl/car_bank_if.sv
// Control and bus-side signals of the register bank; clock and clear stay outside.
interface car_bank_if #(
  parameter int NUM_CAR = 5,
  parameter int WIDTH   = 16
);
  localparam int IDX_W = $clog2(NUM_CAR);

  logic [NUM_CAR-1:0]       inc;
  logic [NUM_CAR-1:0]       dec;
  logic [1:0]               step;
  logic [NUM_CAR-1:0]       load;
  logic [WIDTH-1:0]         xbus_in;
  logic [NUM_CAR-1:0]       addr_sel;
  logic [NUM_CAR-1:0]       xbus_sel;
  logic                     swap_en;
  logic [IDX_W-1:0]         swap_a;
  logic [IDX_W-1:0]         swap_b;
  logic                     conflict_ack;
  logic [WIDTH-1:0]         addr_out;
  logic                     addr_oe;
  logic [WIDTH-1:0]         xbus_out;
  logic                     xbus_oe;
  logic                     conflict;
  logic [NUM_CAR*WIDTH-1:0] car_q;

  modport master (
    output inc, dec, step, load, xbus_in, addr_sel, xbus_sel,
           swap_en, swap_a, swap_b, conflict_ack,
    input  addr_out, addr_oe, xbus_out, xbus_oe, conflict, car_q
  );

  modport slave (
    input  inc, dec, step, load, xbus_in, addr_sel, xbus_sel,
           swap_en, swap_a, swap_b, conflict_ack,
    output addr_out, addr_oe, xbus_out, xbus_oe, conflict, car_q
  );
endinterface

// File: rtl/car_cell.sv
// One counter/address register: clear > swap > load > inc^dec > hold.
module car_cell
  import car_pkg::*;
#(
  parameter int WIDTH = CAR_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic             i_swap,
  input  logic [WIDTH-1:0] i_swap_d,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_d,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [1:0]       i_step,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_delta;

  assign w_delta = WIDTH'(1) << i_step;

  // inc and dec together cancel, so only the xor case modifies
  always_ff @(posedge i_clk) begin
    if (i_clr)              r_q <= i_rst_val;
    else if (i_swap)        r_q <= i_swap_d;
    else if (i_load)        r_q <= i_load_d;
    else if (i_inc ^ i_dec) r_q <= i_inc ? r_q + w_delta : r_q - w_delta;
  end

  assign o_q = r_q;
endmodule

// File: rtl/car_bank.sv
// Parametrised bank of counter/address registers with swap routing,
// lowest-index output muxes and sticky select-contention flag.
module car_bank
  import car_pkg::*;
#(
  parameter int                       NUM_CAR    = 5,
  parameter int                       WIDTH      = CAR_WIDTH,
  parameter logic [NUM_CAR*WIDTH-1:0] RESET_VALS = '0,
  parameter int                       IDX_W      = $clog2(NUM_CAR)
) (
  input  logic      clock,
  input  logic      clear,
  car_bank_if.slave bus
);
  logic [NUM_CAR-1:0][WIDTH-1:0] w_q;
  logic [NUM_CAR-1:0][WIDTH-1:0] w_swap_d;
  logic [NUM_CAR-1:0]            w_swap_hit;
  logic                          w_swap_ok;
  logic [WIDTH-1:0]              w_q_a, w_q_b;
  logic [WIDTH-1:0]              w_addr_mux, w_xbus_mux;
  logic                          w_multi;
  logic                          r_conflict;

  // Out-of-range or identical indices make the swap a no-op for every channel
  assign w_swap_ok = bus.swap_en
                   && (32'(bus.swap_a) < NUM_CAR)
                   && (32'(bus.swap_b) < NUM_CAR)
                   && (bus.swap_a != bus.swap_b);
  assign w_q_a = w_swap_ok ? w_q[bus.swap_a] : '0;
  assign w_q_b = w_swap_ok ? w_q[bus.swap_b] : '0;

  for (genvar i = 0; i < NUM_CAR; i++) begin : g_cell
    assign w_swap_hit[i] = w_swap_ok &&
                           ((bus.swap_a == IDX_W'(i)) || (bus.swap_b == IDX_W'(i)));
    assign w_swap_d[i]   = (bus.swap_a == IDX_W'(i)) ? w_q_b : w_q_a;

    car_cell #(.WIDTH(WIDTH)) u_cell (
      .i_clk     (clock),
      .i_clr     (clear),
      .i_rst_val (RESET_VALS[i*WIDTH +: WIDTH]),
      .i_swap    (w_swap_hit[i]),
      .i_swap_d  (w_swap_d[i]),
      .i_load    (bus.load[i]),
      .i_load_d  (bus.xbus_in),
      .i_inc     (bus.inc[i]),
      .i_dec     (bus.dec[i]),
      .i_step    (bus.step),
      .o_q       (w_q[i])
    );
  end

  // Scan high to low so the lowest selected index wins on multi-hot
  always_comb begin
    w_addr_mux = '0;
    w_xbus_mux = '0;
    for (int i = NUM_CAR - 1; i >= 0; i--) begin
      if (bus.addr_sel[i]) w_addr_mux = w_q[i];
      if (bus.xbus_sel[i]) w_xbus_mux = w_q[i];
    end
  end

  assign w_multi = ((bus.addr_sel & (bus.addr_sel - NUM_CAR'(1))) != '0)
                || ((bus.xbus_sel & (bus.xbus_sel - NUM_CAR'(1))) != '0);

  always_ff @(posedge clock) begin
    if (clear)                 r_conflict <= 1'b0;
    else if (w_multi)          r_conflict <= 1'b1;
    else if (bus.conflict_ack) r_conflict <= 1'b0;
  end

  assign bus.addr_out = w_addr_mux;
  assign bus.addr_oe  = |bus.addr_sel;
  assign bus.xbus_out = w_xbus_mux;
  assign bus.xbus_oe  = |bus.xbus_sel;
  assign bus.conflict = r_conflict;
  assign bus.car_q    = w_q;
endmodule
